// File: rtl/sample_fifo_packer.sv
// sample_fifo_packer: pairs 16-bit input samples into 32-bit words, buffers
// them in a DEPTH-entry FIFO and presents them on a valid/ready interface.
// Supports flushing a trailing half-word and a sticky overflow flag.
module sample_fifo_packer #(
    parameter int          LOG_DEPTH = 9,
    parameter logic [15:0] PAD       = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [15:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOG_DEPTH:0]   level,
    output logic                 pending,
    output logic                 overflow
);

    localparam int                DEPTH      = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_LEVEL = {1'b1, {LOG_DEPTH{1'b0}}};
    localparam logic [LOG_DEPTH:0] LVL_ONE    = {{LOG_DEPTH{1'b0}}, 1'b1};
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = {{(LOG_DEPTH-1){1'b0}}, 1'b1};

    logic [31:0]          mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   level_q, level_d;
    logic [15:0]          half_q, half_d;
    logic                 pending_q, pending_d;
    logic                 overflow_q, overflow_d;

    logic                 full;
    logic                 accept;
    logic                 push_req;
    logic                 do_push;
    logic                 do_pop;
    logic [31:0]          push_data;

    assign full      = (level_q == FULL_LEVEL);
    assign in_ready  = !pending_q || !full;
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign accept    = in_valid && in_ready;

    // Packer decisions, push/pop arbitration and next-state computation.
    // A push requested while the FIFO is full is dropped and flagged as overflow
    // (only reachable via a flush, since a pending pairing requires room).
    always_comb begin
        half_d     = half_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        push_req   = 1'b0;
        push_data  = '0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        do_push    = 1'b0;
        do_pop     = 1'b0;

        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end else if (accept) begin
            if (pending_q) begin
                push_req  = 1'b1;
                push_data = {in_data, half_q};
                pending_d = 1'b0;
            end else if (flush) begin
                push_req  = 1'b1;
                push_data = {PAD, in_data};
            end else begin
                half_d    = in_data;
                pending_d = 1'b1;
            end
        end else if (flush && pending_q) begin
            push_req  = 1'b1;
            push_data = {PAD, half_q};
            pending_d = 1'b0;
        end

        if (push_req && full) begin
            overflow_d = 1'b1;
        end
        do_push = push_req && !full;
        do_pop  = out_ready && (level_q != '0);

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_ONE;
        end

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            pending_d  = 1'b0;
            overflow_d = 1'b0;
            do_push    = 1'b0;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            half_q     <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            half_q     <= half_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_sample_fifo_packer.sv
// Testbench for sample_fifo_packer (LOG_DEPTH = 2): directed scenarios plus a
// randomized stream, checked against a queue-based reference model.
module tb_sample_fifo_packer;

    localparam int          LD    = 2;
    localparam int          DEPTH = 4;
    localparam logic [15:0] PAD   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, flush, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, pending, overflow;
    logic [31:0] out_data;
    logic [LD:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [15:0] m_half;
    bit          m_pend, m_ovf;

    sample_fifo_packer #(.LOG_DEPTH(LD)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .pending(pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Expected {out_valid, in_ready, level, pending, overflow} from the model
    function automatic logic [LD+4:0] m_status();
        logic [LD:0] lv;
        lv = LD'(0) + (LD+1)'(mq.size());
        return {mq.size() != 0, !m_pend || (mq.size() != DEPTH), lv, m_pend, m_ovf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = 0;
        m_ovf  = 0;
        m_half = '0;
    endtask

    // Apply the behavioural rules for one clock edge using current inputs
    task automatic model_step();
        bit          full, rdy, have_push, pop_now;
        logic [31:0] pw;
        if (clear) begin
            model_reset();
            return;
        end
        full      = (mq.size() == DEPTH);
        rdy       = !m_pend || !full;
        have_push = 0;
        pw        = '0;
        pop_now   = out_ready && (mq.size() != 0);
        if (in_valid && !rdy) begin
            m_ovf = 1;
        end else if (in_valid) begin
            if (m_pend) begin
                pw = {in_data, m_half}; have_push = 1; m_pend = 0;
            end else if (flush) begin
                pw = {PAD, in_data}; have_push = 1;
            end else begin
                m_half = in_data; m_pend = 1;
            end
        end else if (flush && m_pend) begin
            pw = {PAD, m_half}; have_push = 1; m_pend = 0;
        end
        if (pop_now) void'(mq.pop_front());
        if (have_push) begin
            if (full) m_ovf = 1;
            else mq.push_back(pw);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 0; in_valid = 0; flush = 0; in_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; out_ready = 0;
        idle_inputs();
        model_reset();
        #12;
        n_checks++;
        if ({out_valid, in_ready, level, pending, overflow} !== {1'b1 == 0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", {out_valid, in_ready, level, pending, overflow}, 7'b0100000);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_pairing();
        logic [15:0] words [4];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = words[i]; step();
            idle_inputs(); step();
        end
        n_checks++;
        if ({level, pending} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL pairing_level: got level=%0d pending=%b expected level=2 pending=0", level, pending);
        end
        n_checks++;
        if ({out_valid, in_ready, level, pending, overflow} !== m_status()) begin
            n_fail++;
            $display("FAIL pairing_status: got %b expected %b", {out_valid, in_ready, level, pending, overflow}, m_status());
        end
        out_ready = 1;
        n_checks++;
        if (!(out_valid === 1'b1 && out_data === 32'h2222_1111)) begin
            n_fail++;
            $display("FAIL pairing_pop0: got %h (valid %b) expected 22221111", out_data, out_valid);
        end
        step();
        n_checks++;
        if (!(out_valid === 1'b1 && out_data === 32'h4444_3333)) begin
            n_fail++;
            $display("FAIL pairing_pop1: got %h (valid %b) expected 44443333", out_data, out_valid);
        end
        step();
        out_ready = 0;
        n_checks++;
        if ({out_valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL pairing_drained: got valid=%b level=%0d expected 0/0", out_valid, level);
        end
    endtask

    task automatic test_flush();
        out_ready = 0;
        in_valid = 1; in_data = 16'hABCD; step();
        idle_inputs();
        n_checks++;
        if ({pending, level} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL flush_pending_set: got pending=%b level=%0d expected 1/0", pending, level);
        end
        flush = 1; step(); flush = 0;
        n_checks++;
        if ({pending, level, out_valid, out_data} !== {1'b0, 3'd1, 1'b1, 32'h0000_ABCD}) begin
            n_fail++;
            $display("FAIL flush_push: got pending=%b level=%0d data=%h expected 0/1/0000abcd", pending, level, out_data);
        end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_simul_flush();
        out_ready = 0;
        in_valid = 1; flush = 1; in_data = 16'h5555; step();
        idle_inputs();
        n_checks++;
        if ({pending, level, out_data} !== {1'b0, 3'd1, 32'h0000_5555}) begin
            n_fail++;
            $display("FAIL simflush_a: got pending=%b level=%0d data=%h expected 0/1/00005555", pending, level, out_data);
        end
        out_ready = 1; step(); out_ready = 0;
        in_valid = 1; in_data = 16'h1234; step();
        in_valid = 1; flush = 1; in_data = 16'h5555; step();
        idle_inputs();
        step(); step();
        n_checks++;
        if ({pending, level, out_data} !== {1'b0, 3'd1, 32'h5555_1234}) begin
            n_fail++;
            $display("FAIL simflush_b: got pending=%b level=%0d data=%h expected 0/1/55551234", pending, level, out_data);
        end
        out_ready = 1; step(); out_ready = 0;
        n_checks++;
        if ({out_valid, in_ready, level, pending, overflow} !== m_status()) begin
            n_fail++;
            $display("FAIL simflush_status: got %b expected %b", {out_valid, in_ready, level, pending, overflow}, m_status());
        end
    endtask

    task automatic test_full_overflow();
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 16'($urandom); step();
        end
        idle_inputs();
        n_checks++;
        if ({level, pending, in_ready} !== {3'd4, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_level: got level=%0d pending=%b in_ready=%b expected 4/0/1", level, pending, in_ready);
        end
        n_checks++;
        if (out_data !== mq[0]) begin
            n_fail++;
            $display("FAIL full_head: got %h expected %h", out_data, mq[0]);
        end
        in_valid = 1; in_data = 16'h9999; step();
        idle_inputs();
        n_checks++;
        if ({pending, overflow, in_ready} !== {1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL full_ninth: got pending=%b overflow=%b in_ready=%b expected 1/0/0", pending, overflow, in_ready);
        end
        in_valid = 1; in_data = 16'hAAAA; step();
        idle_inputs();
        n_checks++;
        if ({overflow, level, pending} !== {1'b1, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL full_tenth: got overflow=%b level=%0d pending=%b expected 1/4/1", overflow, level, pending);
        end
        flush = 1; step(); flush = 0;
        n_checks++;
        if ({overflow, level, pending} !== {1'b1, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL full_flush_drop: got overflow=%b level=%0d pending=%b expected 1/4/0", overflow, level, pending);
        end
        clear = 1; out_ready = 1; step(); clear = 0; out_ready = 0;
        n_checks++;
        if ({out_valid, level, pending, overflow} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear: got valid=%b level=%0d pending=%b overflow=%b expected all 0", out_valid, level, pending, overflow);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] win [40];
        logic [31:0] exp_w;
        int sent = 0;
        int popped = 0;
        int bad = 0;
        for (int i = 0; i < 40; i++) win[i] = 16'($urandom);
        for (int cyc = 0; cyc < 400 && popped < 20; cyc++) begin
            idle_inputs();
            if (cyc % 2 == 0 && sent < 40) begin
                in_valid = 1; in_data = win[sent]; sent++;
            end
            out_ready = ($urandom_range(0, 99) < 70);
            if (out_ready && out_valid) begin
                exp_w = {win[2*popped+1], win[2*popped]};
                n_checks++;
                if (out_data !== exp_w) begin
                    n_fail++; bad++;
                    if (bad < 5) $display("FAIL wrap_word%0d: got %h expected %h", popped, out_data, exp_w);
                end
                popped++;
            end
            step();
        end
        idle_inputs(); out_ready = 0;
        n_checks++;
        if (popped != 20) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d words expected 20", popped);
        end
        n_checks++;
        if ({overflow, level, pending} !== {1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_final: got overflow=%b level=%0d pending=%b expected 0/0/0", overflow, level, pending);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1; in_data = 16'($urandom); step();
        end
        idle_inputs();
        n_checks++;
        if ({level, pending} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got level=%0d pending=%b expected 3/1", level, pending);
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if ({out_valid, in_ready, level, pending, overflow} !== m_status()) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b expected %b", {out_valid, in_ready, level, pending, overflow}, m_status());
        end
        @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready, level, pending, overflow} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_release: got %b expected 0100000", {out_valid, in_ready, level, pending, overflow});
        end
    endtask

    initial begin
        test_reset();
        test_pairing();
        test_flush();
        test_simul_flush();
        test_full_overflow();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
